// File: rtl/lexington_pkg.sv
// Shared types and defaults for the AXI4-Lite single-transfer master.
package lexington_pkg;

   localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
   localparam int DEFAULT_AXI_TIMEOUT = 255;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_RESP,
      ST_DONE
   } axi_lite_state_t;

   // Anything other than OKAY (EXOKAY included) is reported to the core as a fault.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp != OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_master_watchdog.sv
// Response watchdog: counts consecutive cycles with 'run' high and flags the LIMIT-th one.
module axi_watchdog
   import lexington_pkg::*;
#(
   parameter int LIMIT = DEFAULT_AXI_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign expired = run && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_master.sv
// Bridges a stalling core read/write request onto AXI4-Lite, one transfer at a time.
// Optional response watchdog enabled by defining AXI_TIMEOUT_EN.
module axi_lite_master
   import lexington_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rd_en,
   input  logic                      wr_en,
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   input  logic [31:0]               wr_data,
   input  logic [3:0]                wr_strobe,
   output logic [31:0]               rd_data,
   output logic                      access_fault,
   output logic                      busy,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [31:0]               m_axi_wdata,
   output logic [3:0]                m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [31:0]               m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axi_lite_master: TIMEOUT_CYCLES must be at least 1");
   end

   axi_lite_state_t state, state_next;

   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]               wdata_q;
   logic [3:0]                strb_q;
   logic                      write_q;
   logic                      aw_done;
   logic                      w_done;
   logic [31:0]               rd_data_q;
   logic                      fault_q;

   logic request;
   logic accept;
   logic aw_hs, w_hs, ar_hs;
   logic resp_hit;
   logic timed_out;
   logic stale_bready;
   logic stale_rready;

`ifdef AXI_TIMEOUT_EN
   logic stale;
   logic stale_write;

   // A timed-out transfer leaves its ready raised so the late response is swallowed.
   axi_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .run    ((state == ST_RESP) && !resp_hit),
      .expired(timed_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stale       <= 1'b0;
         stale_write <= 1'b0;
      end else if (timed_out) begin
         stale       <= 1'b1;
         stale_write <= write_q;
      end else if (stale && (stale_write ? m_axi_bvalid : m_axi_rvalid)) begin
         stale <= 1'b0;
      end
   end

   assign stale_bready = stale && stale_write;
   assign stale_rready = stale && !stale_write;
   assign accept       = request && !stale;
`else
   assign timed_out    = 1'b0;
   assign stale_bready = 1'b0;
   assign stale_rready = 1'b0;
   assign accept       = request;
`endif

   assign request = rd_en || wr_en;
   assign busy    = !rst && request && (state != ST_DONE);

   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = strb_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_awvalid = !rst && (state == ST_ADDR) && write_q && !aw_done;
   assign m_axi_wvalid  = !rst && (state == ST_ADDR) && write_q && !w_done;
   assign m_axi_arvalid = !rst && (state == ST_ADDR) && !write_q;
   assign m_axi_bready  = !rst && (((state == ST_RESP) && write_q) || stale_bready);
   assign m_axi_rready  = !rst && (((state == ST_RESP) && !write_q) || stale_rready);

   assign aw_hs    = m_axi_awvalid && m_axi_awready;
   assign w_hs     = m_axi_wvalid && m_axi_wready;
   assign ar_hs    = m_axi_arvalid && m_axi_arready;
   assign resp_hit = (state == ST_RESP) && (write_q ? m_axi_bvalid : m_axi_rvalid);

   assign rd_data      = rd_data_q;
   assign access_fault = fault_q && (state == ST_DONE);

   // Write address and data may complete in either order; leave ADDR once both have.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) state_next = ST_ADDR;
         end
         ST_ADDR: begin
            if (write_q) begin
               if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = ST_RESP;
            end else if (ar_hs) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_hit || timed_out) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         write_q   <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rd_data_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state <= state_next;
         if ((state == ST_IDLE) && accept) begin
            addr_q  <= addr;
            wdata_q <= wr_data;
            strb_q  <= wr_strobe;
            write_q <= wr_en;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == ST_ADDR) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
         end
         // Writes report zero read data so a stale read value never looks current.
         if (resp_hit) begin
            rd_data_q <= write_q ? 32'h0 : m_axi_rdata;
            fault_q   <= resp_is_error(write_q ? m_axi_bresp : m_axi_rresp);
         end else if (timed_out) begin
            rd_data_q <= 32'h0;
            fault_q   <= 1'b1;
         end
      end
   end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default DEFAULT_AXI_ADDR_WIDTH: byte-address width of AXI space.
REQ-002 Parameter TIMEOUT_CYCLES, default DEFAULT_AXI_TIMEOUT (255): response watchdog limit, used only with AXI_TIMEOUT_EN.
REQ-003 clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rd_en  input  1  core read request; held stable while busy=1.
REQ-006 wr_en  input  1  core write request; held stable while busy=1.
REQ-007 addr  input  AXI_ADDR_WIDTH  core byte address.
REQ-008 wr_data  input  32  core write data.
REQ-009 wr_strobe  input  4  core byte strobes.
REQ-010 rd_data  output  32  read data; valid in DONE only.
REQ-011 access_fault  output  1  error for completing transfer; valid in DONE only.
REQ-012 busy  output  1  core stall request.
REQ-013 m_axi_aw{addr,valid,ready}  out/out/in  AXI_ADDR_WIDTH/1/1  write address channel; awprot tied 3'b000.
REQ-014 m_axi_w{data,strb,valid,ready}  out/out/out/in  32/4/1/1  write data channel.
REQ-015 m_axi_b{resp,valid,ready}  in/in/out  2/1/1  write response channel.
REQ-016 m_axi_ar{addr,valid,ready}  out/out/in  AXI_ADDR_WIDTH/1/1  read address channel; arprot tied 3'b000.
REQ-017 m_axi_r{data,resp,valid,ready}  in/in/in/out  32/2/1/1  read data channel.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, RESP, DONE; exactly one transfer outstanding.
REQ-019 busy SHALL equal (rd_en|wr_en) & (state!=DONE), combinational; busy=0 in DONE releases the core.
REQ-020 IDLE + request SHALL register addr/data/strobe/direction and go to ADDR; wr_en wins if both asserted.
REQ-021 ADDR write SHALL assert awvalid and wvalid together and drop each independently on its handshake; go to RESP once both done, same-cycle or either order.
REQ-022 ADDR read SHALL assert arvalid until arready, then go to RESP.
REQ-023 VALID SHALL never deassert before READY, and address/data SHALL be stable while VALID is high.
REQ-024 RESP SHALL hold bready/rready=1, capture rdata and access_fault=(resp!=2'b00) on bvalid/rvalid, then go to DONE.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE; the next request is accepted no earlier than IDLE.
REQ-026 Zero-wait slave: request seen at cycle N, busy=0 at N+3; each slave wait cycle adds one.
REQ-027 rd_data SHALL be 0 on writes and hold its value outside DONE; access_fault SHALL be 0 outside DONE.

Reset
REQ-028 rst SHALL force IDLE, clear all VALID/READY, rd_data=0, access_fault=0, and abandon any transfer, including mid-handshake; busy=0 while rst=1.

Configuration
REQ-029 With AXI_TIMEOUT_EN defined, RESP SHALL count cycles; after TIMEOUT_CYCLES without response, go to DONE with access_fault=1, set stale flag, keep the stale ready high, discard the late response, and hold new requests in IDLE (busy=1) until it arrives; without the macro, RESP waits indefinitely and no counter or flag exists.

Structure
REQ-030 lexington package SHALL hold axi_resp_t (OKAY, EXOKAY, SLVERR, DECERR), axi_lite_state_t, and DEFAULT_AXI_TIMEOUT.
REQ-031 Watchdog counter SHALL be sub-module axi_watchdog, instantiated only under AXI_TIMEOUT_EN.

Verification
REQ-032 Read 0x0000_0010, zero-wait slave, rdata 0xDEADBEEF, OKAY -> busy 1 for 3 cycles, then DONE with rd_data=0xDEADBEEF, access_fault=0.
REQ-033 Write 0x1234_5678, strobe 4'b0011, wready 2 cycles after awready -> AW/W values stable until their handshakes; fault=0; busy low one cycle after bvalid.
REQ-034 Read, rresp=SLVERR -> access_fault=1 in DONE only; write, bresp=DECERR -> access_fault=1.
REQ-035 rst pulsed while arvalid=1 and arready=0 -> next cycle IDLE, arvalid=0, busy=0, rd_data=0.
REQ-036 AXI_TIMEOUT_EN, TIMEOUT_CYCLES=8, rvalid withheld 20 cycles -> fault at timeout; next read stalls until late rvalid is consumed, then completes normally.
